max7219_chain_driver: RTL and testbench
=======================================

Name: max7219_chain_driver

Overview:
- Parametrised successor to the single-device LED-matrix SPI path in the FPGA fabric beside soc_system.
- Drives a daisy chain of N MAX7219 devices over a 3-wire SPI link (SCLK/DIN/LOAD).
- Runs an automatic power-up init sequence, then accepts per-register writes that carry independent data for every device in the chain in one LOAD frame.

Parameters:
- N_DEVICES, 4: number of chained MAX7219s; legal range 1..16.
- CLK_DIV, 4: clk_clk cycles per SCLK half-period; must be at least 1.
- CS_HIGH_CYCLES, 8: clk_clk cycles spi_cs_n is held high after each frame; must be at least CLK_DIV.
- INTENSITY, 4'h8: intensity register value written during init.
- AUTO_INIT, 1: 1 = run the init sequence automatically after reset release.

Ports:
- clk_clk  in  1  sole clock.
- reset_reset  in  1  synchronous active-high reset.
- cmd_valid  in  1  write request.
- cmd_ready  out  1  request accepted when cmd_valid && cmd_ready.
- cmd_addr  in  4  MAX7219 register address; 0 (no-op) is legal.
- cmd_data  in  8*N_DEVICES  byte k goes to device k (device 0 is nearest the FPGA).
- init_req  in  1  single-cycle request to rerun the init sequence.
- busy  out  1  high while a frame or the init sequence is in progress.
- init_done  out  1  high once the init sequence has completed.
- spi_sclk  out  1  SPI clock, idles low.
- spi_mosi  out  1  serial data to DIN of device 0.
- spi_cs_n  out  1  LOAD/CS, active low.

Behaviour:
- Clock and reset: one clock, clk_clk. Reset is synchronous and active-high on reset_reset.
- Reset values: spi_cs_n=1, spi_sclk=0, spi_mosi=0, cmd_ready=0, busy=0, init_done=0. Any pending init request is cleared.
- Reset asserted mid-frame: the link is forced idle at the next clock edge and no partial LOAD rising edge is generated beyond that.
- States: IDLE, LOAD, SHIFT_LO, SHIFT_HI, TAIL, GAP, INIT_NEXT.
- Frame contents:
  - Each frame is N_DEVICES 16-bit words, word = {4'h0, addr[3:0], data[7:0]}, MSB first.
  - The word for device N_DEVICES-1 is shifted first, so device 0's word is shifted last.
  - Frame data is captured into a shift register at acceptance; later changes on cmd_data/cmd_addr are ignored.
- Timing (SPI mode 0):
  - LOAD: spi_cs_n=0 and MOSI driven with bit 0 of the frame for CLK_DIV cycles.
  - Each bit is SHIFT_HI (sclk=1, CLK_DIV cycles), then SHIFT_LO (sclk=0, next bit presented, CLK_DIV cycles). MOSI changes only while sclk is low.
  - After the last high phase: TAIL (sclk=0, cs_n=0, CLK_DIV cycles), then GAP (cs_n=1, CS_HIGH_CYCLES cycles), then IDLE.
  - spi_cs_n is low for exactly (32*N_DEVICES+1)*CLK_DIV cycles per frame.
  - The bit counter spans 16*N_DEVICES and does not wrap within a frame.
- Handshake:
  - cmd_ready = (state==IDLE) && init_done && !init_pending.
  - Acceptance moves to LOAD on the next edge; busy rises the same edge and falls on GAP→IDLE.
- Init sequence: 13 broadcast frames, each word identical across all devices, in this order:
  - 0x0F00 (test off), 0x0B07 (scan limit), 0x0900 (no decode), 0x0A0{INTENSITY}, 0x0C01 (normal operation).
  - Then 0x0100 through 0x0800 (clear rows).
  - init_done rises when the GAP of frame 13 ends, in the same cycle busy falls.
- Init start:
  - AUTO_INIT=1: init starts on the first cycle after reset deasserts.
  - init_req while busy: latched as init_pending and started after the current frame's GAP. A command is never interrupted.
  - init_req in IDLE: starts immediately and wins over a simultaneous cmd_valid, which is not accepted.
  - init_done drops to 0 when a re-init starts.
  - AUTO_INIT=0: the link stays idle and cmd_ready stays 0 until init_req.

Test Plan:
1. N_DEVICES=4, CLK_DIV=2, AUTO_INIT=1, release reset -> 13 frames; each has cs_n low 258 cycles and 64 rising sclk edges. Frame 1 MOSI = 0x0F00 four times, frame 4 = 0x0A08 four times. init_done=1 after the final 8-cycle gap.
2. After init, cmd_addr=3, cmd_data=0x11223344 -> MOSI 0x0311, 0x0322, 0x0333, 0x0344 in that order. cmd_ready is low from the acceptance edge until idle.
3. Hold cmd_valid during busy and change cmd_data before acceptance -> exactly one frame, carrying the value present at the acceptance edge. No frame overlap; gap >= CS_HIGH_CYCLES.
4. Assert reset_reset mid-SHIFT_HI of bit 20 -> next edge gives cs_n=1, sclk=0, mosi=0, init_done=0. On release, init restarts from 0x0F00.
5. In IDLE, pulse init_req together with cmd_valid -> init runs first and the command is accepted only after init_done. A second init_req pulsed mid-init is latched and runs exactly one more sequence.
6. N_DEVICES=1, CLK_DIV=1, CS_HIGH_CYCLES=1 -> cs_n low 33 cycles per frame, sclk period 2 cycles, 16 bits per frame, correct word MSB first.

Source files
------------

// File: rtl/max7219_chain_driver.sv
// max7219_chain_driver
// Drives a daisy chain of N_DEVICES MAX7219 LED drivers over a 3-wire SPI
// link (SCLK / DIN / LOAD), SPI mode 0.  After reset it can run a power-up
// init sequence of 13 broadcast frames.  After that it accepts per-register
// writes, each carrying an independent data byte for every device.
//
// Ports
//   clk_clk, reset_reset   sole clock; synchronous active-high reset
//   cmd_valid/cmd_ready    write request handshake
//   cmd_addr               MAX7219 register address (0 = no-op)
//   cmd_data               byte k goes to device k (device 0 nearest FPGA)
//   init_req               single-cycle request to rerun the init sequence
//   busy                   high while a frame or init sequence is in progress
//   init_done              high once the init sequence has completed
//   spi_sclk/mosi/cs_n     SPI link; sclk idles low, cs_n is LOAD (active low)
//
// Handshake: a command transfers on a rising clk_clk edge where cmd_valid and
// cmd_ready are both high.  cmd_addr/cmd_data must be stable for that edge and
// are captured then; later changes have no effect.  cmd_ready depends only on
// internal state, never combinationally on cmd_valid.
module max7219_chain_driver #(
  parameter int       N_DEVICES      = 4,
  parameter int       CLK_DIV        = 4,
  parameter int       CS_HIGH_CYCLES = 8,
  parameter bit [3:0] INTENSITY      = 4'h8,
  parameter bit       AUTO_INIT      = 1'b1
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [3:0]             cmd_addr,
  input  logic [8*N_DEVICES-1:0] cmd_data,
  input  logic                   init_req,
  output logic                   busy,
  output logic                   init_done,
  output logic                   spi_sclk,
  output logic                   spi_mosi,
  output logic                   spi_cs_n
);

  localparam int FW      = 16 * N_DEVICES;
  localparam int BW      = $clog2(FW + 1);
  localparam int CNT_MAX = (CLK_DIV > CS_HIGH_CYCLES) ? CLK_DIV : CS_HIGH_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SHIFT_LO, S_SHIFT_HI, S_TAIL, S_GAP, S_INIT_NEXT
  } state_t;

  state_t          state_q, state_d;
  logic [FW-1:0]   sr_q, sr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [3:0]      init_idx_q, init_idx_d;
  logic            in_init_q, in_init_d;
  logic            init_done_q, init_done_d;
  logic            init_pending_q, init_pending_d;
  logic            auto_q, auto_d;
  logic            sclk_q, sclk_d;
  logic            mosi_q, mosi_d;
  logic            cs_n_q, cs_n_d;
  logic [FW-1:0]   cmd_frame;
  logic            phase_end, gap_end, start_init;

  // Init word for frame idx (0..12); rows 1..8 are cleared by idx 5..12.
  function automatic logic [15:0] init_word(input logic [3:0] idx);
    case (idx)
      4'd0:    init_word = 16'h0F00;
      4'd1:    init_word = 16'h0B07;
      4'd2:    init_word = 16'h0900;
      4'd3:    init_word = {12'h0A0, INTENSITY};
      4'd4:    init_word = 16'h0C01;
      default: init_word = {4'h0, idx - 4'd4, 8'h00};
    endcase
  endfunction

  assign cmd_ready = (state_q == S_IDLE) && init_done_q && !init_pending_q;
  assign busy      = (state_q != S_IDLE);
  assign init_done = init_done_q;
  assign spi_sclk  = sclk_q;
  assign spi_mosi  = mosi_q;
  assign spi_cs_n  = cs_n_q;

  assign phase_end  = (cnt_q == CW'(CLK_DIV - 1));
  assign gap_end    = (cnt_q == CW'(CS_HIGH_CYCLES - 1));
  assign start_init = init_req || init_pending_q || auto_q;

  always_comb begin
    state_d        = state_q;
    sr_d           = sr_q;
    cnt_d          = cnt_q;
    bit_d          = bit_q;
    init_idx_d     = init_idx_q;
    in_init_d      = in_init_q;
    init_done_d    = init_done_q;
    auto_d         = auto_q;
    init_pending_d = init_pending_q | init_req;
    cmd_frame      = '0;

    // Device N_DEVICES-1 sits in the MSBs so it leaves the shifter first.
    for (int k = 0; k < N_DEVICES; k++) begin
      cmd_frame[16*k +: 16] = {4'h0, cmd_addr, cmd_data[8*k +: 8]};
    end

    case (state_q)
      S_IDLE: begin
        if (start_init) begin
          // Init outranks a simultaneous command, which stays unaccepted.
          state_d        = S_INIT_NEXT;
          init_idx_d     = 4'd0;
          in_init_d      = 1'b1;
          init_done_d    = 1'b0;
          init_pending_d = 1'b0;
          auto_d         = 1'b0;
        end else if (cmd_valid && cmd_ready) begin
          state_d = S_LOAD;
          sr_d    = cmd_frame;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      S_INIT_NEXT: begin
        state_d    = S_LOAD;
        sr_d       = {N_DEVICES{init_word(init_idx_q)}};
        init_idx_d = init_idx_q + 4'd1;
        cnt_d      = '0;
        bit_d      = '0;
      end
      S_LOAD: begin
        cnt_d = cnt_q + CW'(1);
        if (phase_end) begin
          state_d = S_SHIFT_HI;
          cnt_d   = '0;
        end
      end
      S_SHIFT_HI: begin
        cnt_d = cnt_q + CW'(1);
        if (phase_end) begin
          cnt_d = '0;
          if (bit_q == BW'(FW - 1)) begin
            state_d = S_TAIL;
          end else begin
            // Next bit is presented while sclk is low.
            state_d = S_SHIFT_LO;
            bit_d   = bit_q + BW'(1);
            sr_d    = {sr_q[FW-2:0], 1'b0};
          end
        end
      end
      S_SHIFT_LO: begin
        cnt_d = cnt_q + CW'(1);
        if (phase_end) begin
          state_d = S_SHIFT_HI;
          cnt_d   = '0;
        end
      end
      S_TAIL: begin
        cnt_d = cnt_q + CW'(1);
        if (phase_end) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end
      end
      S_GAP: begin
        cnt_d = cnt_q + CW'(1);
        if (gap_end) begin
          cnt_d = '0;
          if (in_init_q && (init_idx_q == 4'd13)) begin
            state_d     = S_IDLE;
            in_init_d   = 1'b0;
            init_done_d = 1'b1;
          end else if (in_init_q) begin
            state_d = S_INIT_NEXT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Link pins are registered from the next state so they switch cleanly
    // on the same edge as the state register.
    cs_n_d = !(state_d inside {S_LOAD, S_SHIFT_HI, S_SHIFT_LO, S_TAIL});
    sclk_d = (state_d == S_SHIFT_HI);
    mosi_d = (state_d inside {S_LOAD, S_SHIFT_HI, S_SHIFT_LO}) ? sr_d[FW-1] : 1'b0;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q        <= S_IDLE;
      sr_q           <= '0;
      cnt_q          <= '0;
      bit_q          <= '0;
      init_idx_q     <= 4'd0;
      in_init_q      <= 1'b0;
      init_done_q    <= 1'b0;
      init_pending_q <= 1'b0;
      auto_q         <= AUTO_INIT;
      sclk_q         <= 1'b0;
      mosi_q         <= 1'b0;
      cs_n_q         <= 1'b1;
    end else begin
      state_q        <= state_d;
      sr_q           <= sr_d;
      cnt_q          <= cnt_d;
      bit_q          <= bit_d;
      init_idx_q     <= init_idx_d;
      in_init_q      <= in_init_d;
      init_done_q    <= init_done_d;
      init_pending_q <= init_pending_d;
      auto_q         <= auto_d;
      sclk_q         <= sclk_d;
      mosi_q         <= mosi_d;
      cs_n_q         <= cs_n_d;
    end
  end

endmodule

// File: tb/tb_max7219_chain_driver.sv
module tb_max7219_chain_driver;

  localparam int NA = 4, DA = 2, GA = 8;
  localparam int NB = 1, DB = 1, GB = 1;
  localparam int BUDGET = 20000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_a, reset_b;

  logic        cmd_valid_a, cmd_ready_a, init_req_a, busy_a, init_done_a;
  logic [3:0]  cmd_addr_a;
  logic [31:0] cmd_data_a;
  logic        spi_sclk_a, spi_mosi_a, spi_cs_n_a;

  logic        cmd_valid_b, cmd_ready_b, init_req_b, busy_b, init_done_b;
  logic [3:0]  cmd_addr_b;
  logic [7:0]  cmd_data_b;
  logic        spi_sclk_b, spi_mosi_b, spi_cs_n_b;

  max7219_chain_driver #(.N_DEVICES(NA), .CLK_DIV(DA), .CS_HIGH_CYCLES(GA),
                         .INTENSITY(4'h8), .AUTO_INIT(1'b1)) dut_a (
    .clk_clk(clk), .reset_reset(reset_a),
    .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
    .cmd_addr(cmd_addr_a), .cmd_data(cmd_data_a),
    .init_req(init_req_a), .busy(busy_a), .init_done(init_done_a),
    .spi_sclk(spi_sclk_a), .spi_mosi(spi_mosi_a), .spi_cs_n(spi_cs_n_a));

  max7219_chain_driver #(.N_DEVICES(NB), .CLK_DIV(DB), .CS_HIGH_CYCLES(GB),
                         .INTENSITY(4'h3), .AUTO_INIT(1'b0)) dut_b (
    .clk_clk(clk), .reset_reset(reset_b),
    .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
    .cmd_addr(cmd_addr_b), .cmd_data(cmd_data_b),
    .init_req(init_req_b), .busy(busy_b), .init_done(init_done_b),
    .spi_sclk(spi_sclk_b), .spi_mosi(spi_mosi_b), .spi_cs_n(spi_cs_n_b));

  // ---------------- scoreboard ----------------
  logic [63:0] exp_a_q[$];
  logic [15:0] exp_b_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: register map of the init sequence and frame layout.
  function automatic logic [15:0] init_w(input int i, input logic [3:0] inten);
    case (i)
      0: return 16'h0F00;
      1: return 16'h0B07;
      2: return 16'h0900;
      3: return {12'h0A0, inten};
      4: return 16'h0C01;
      default: return 16'((i - 4) * 256);
    endcase
  endfunction

  function automatic logic [63:0] frame_a(input logic [3:0] addr, input logic [31:0] data);
    logic [63:0] f = '0;
    for (int k = NA - 1; k >= 0; k--) f = (f << 16) | {48'h0, 4'h0, addr, data[8*k +: 8]};
    return f;
  endfunction

  task automatic push_init_a();
    for (int i = 0; i < 13; i++) exp_a_q.push_back({4{init_w(i, 4'h8)}});
  endtask

  task automatic push_init_b();
    for (int i = 0; i < 13; i++) exp_b_q.push_back(init_w(i, 4'h3));
  endtask

  // ---------------- monitors ----------------
  logic [63:0] a_cap;
  int a_low, a_bits, a_gap, a_frames = 0;
  bit a_in = 0, a_prev_sclk = 0, a_prev_mosi = 0, a_have_prev = 0, a_stable = 1;

  always @(negedge clk) begin
    if (reset_a) begin
      a_in = 0; a_have_prev = 0; a_prev_sclk = 0;
    end else begin
      if (!spi_cs_n_a) begin
        if (!a_in) begin
          if (a_have_prev) check("a_gap_min", 64'(a_gap >= GA), 64'd1);
          a_in = 1; a_low = 0; a_bits = 0; a_cap = '0; a_stable = 1;
        end
        a_low++;
        if (spi_sclk_a && !a_prev_sclk) begin
          a_cap = {a_cap[62:0], spi_mosi_a};
          a_bits++;
        end
        if (spi_sclk_a && a_prev_sclk && spi_mosi_a !== a_prev_mosi) a_stable = 0;
      end else begin
        if (a_in) begin
          if (exp_a_q.size() == 0) check("a_unexpected_frame", a_cap, 64'hx);
          else check("a_frame", a_cap, exp_a_q.pop_front());
          check("a_cs_low_cycles", 64'(a_low), 64'((32 * NA + 1) * DA));
          check("a_sclk_edges", 64'(a_bits), 64'(16 * NA));
          check("a_mosi_stable_hi", 64'(a_stable), 64'd1);
          a_in = 0; a_have_prev = 1; a_gap = 0; a_frames++;
        end
        a_gap++;
      end
      a_prev_sclk = spi_sclk_a; a_prev_mosi = spi_mosi_a;
    end
  end

  logic [15:0] b_cap;
  int b_low, b_bits, b_gap;
  bit b_in = 0, b_prev_sclk = 0, b_have_prev = 0;

  always @(negedge clk) begin
    if (reset_b) begin
      b_in = 0; b_have_prev = 0; b_prev_sclk = 0;
    end else begin
      if (!spi_cs_n_b) begin
        if (!b_in) begin
          if (b_have_prev) check("b_gap_min", 64'(b_gap >= GB), 64'd1);
          b_in = 1; b_low = 0; b_bits = 0; b_cap = '0;
        end
        b_low++;
        if (spi_sclk_b && !b_prev_sclk) begin
          b_cap = {b_cap[14:0], spi_mosi_b};
          b_bits++;
        end
      end else begin
        if (b_in) begin
          if (exp_b_q.size() == 0) check("b_unexpected_frame", 64'(b_cap), 64'hx);
          else check("b_frame", 64'(b_cap), 64'(exp_b_q.pop_front()));
          check("b_cs_low_cycles", 64'(b_low), 64'((32 * NB + 1) * DB));
          check("b_sclk_edges", 64'(b_bits), 64'(16 * NB));
          b_in = 0; b_have_prev = 1; b_gap = 0;
        end
        b_gap++;
      end
      b_prev_sclk = spi_sclk_b;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd_a(input logic [3:0] addr, input logic [31:0] data, input bit vary);
    int c = 0;
    bit ok = 0;
    @(posedge clk); #1;
    cmd_valid_a = 1; cmd_addr_a = addr; cmd_data_a = data;
    while (c < BUDGET) begin
      @(negedge clk);
      if (cmd_ready_a) begin ok = 1; break; end
      c++;
      @(posedge clk); #1;
      if (vary) cmd_data_a = $urandom;
    end
    check("a_cmd_accept_timeout", 64'(ok), 64'd1);
    if (ok) exp_a_q.push_back(frame_a(cmd_addr_a, cmd_data_a));
    @(posedge clk); #1;
    cmd_valid_a = 0;
    cmd_data_a  = $urandom;
    check("a_ready_low_after_accept", 64'(cmd_ready_a), 64'd0);
    check("a_busy_after_accept", 64'(busy_a), 64'd1);
  endtask

  task automatic send_cmd_b(input logic [3:0] addr, input logic [7:0] data);
    int c = 0;
    bit ok = 0;
    @(posedge clk); #1;
    cmd_valid_b = 1; cmd_addr_b = addr; cmd_data_b = data;
    while (c < BUDGET) begin
      @(negedge clk);
      if (cmd_ready_b) begin ok = 1; break; end
      c++;
    end
    check("b_cmd_accept_timeout", 64'(ok), 64'd1);
    if (ok) exp_b_q.push_back({4'h0, addr, data});
    @(posedge clk); #1;
    cmd_valid_b = 0;
  endtask

  task automatic wait_init_a(input string name);
    int c = 0;
    while (!init_done_a && c < BUDGET) begin @(negedge clk); c++; end
    check(name, 64'(init_done_a), 64'd1);
    check({name, "_busy_low"}, 64'(busy_a), 64'd0);
  endtask

  task automatic wait_drain(input string name);
    int c = 0;
    while ((busy_a || busy_b || exp_a_q.size() != 0 || exp_b_q.size() != 0) && c < BUDGET) begin
      @(negedge clk); c++;
    end
    check({name, "_queues_empty"}, 64'(exp_a_q.size() + exp_b_q.size()), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int c;
    cmd_valid_a = 0; cmd_addr_a = 0; cmd_data_a = 0; init_req_a = 0;
    cmd_valid_b = 0; cmd_addr_b = 0; cmd_data_b = 0; init_req_b = 0;
    reset_a = 1; reset_b = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs_n", 64'(spi_cs_n_a), 64'd1);
    check("rst_sclk", 64'(spi_sclk_a), 64'd0);
    check("rst_mosi", 64'(spi_mosi_a), 64'd0);
    check("rst_ready_busy_done", 64'({cmd_ready_a, busy_a, init_done_a}), 64'd0);
    @(posedge clk); #1;
    reset_a = 0; reset_b = 0;
    push_init_a();
    @(posedge clk); #1;
    check("auto_init_busy", 64'(busy_a), 64'd1);
    wait_init_a("a_init1_done");

    // Fixed command, then random commands; some change data while waiting.
    send_cmd_a(4'd3, 32'h11223344, 0);
    for (int i = 0; i < 4; i++) send_cmd_a(4'($urandom_range(0, 15)), $urandom, 0);
    for (int i = 0; i < 3; i++) send_cmd_a(4'($urandom_range(1, 8)), $urandom, 1);
    wait_drain("after_cmds");

    // AUTO_INIT=0 instance stays idle until asked.
    check("b_idle_no_init", 64'({cmd_ready_b, busy_b, init_done_b, spi_cs_n_b}), 64'b0001);

    // Reset in the middle of bit 20 of a frame.
    send_cmd_a(4'($urandom_range(1, 8)), $urandom, 0);
    c = 0;
    while (!(a_bits == 21 && spi_sclk_a && a_in) && c < BUDGET) begin @(posedge clk); #1; c++; end
    check("reach_bit20", 64'(c < BUDGET), 64'd1);
    reset_a = 1;
    exp_a_q.delete();
    @(posedge clk); #1;
    check("midrst_link", 64'({spi_cs_n_a, spi_sclk_a, spi_mosi_a}), 64'b100);
    check("midrst_done_busy", 64'({init_done_a, busy_a}), 64'd0);
    repeat (2) @(posedge clk); #1;
    reset_a = 0;
    push_init_a();
    wait_init_a("a_init2_done");

    // init_req together with cmd_valid in IDLE, plus a second request mid-init.
    @(posedge clk); #1;
    init_req_a = 1; cmd_valid_a = 1; cmd_addr_a = 4'd5; cmd_data_a = $urandom;
    push_init_a();
    @(posedge clk); #1;
    init_req_a = 0;
    check("init_wins_over_cmd", 64'({busy_a, cmd_ready_a, init_done_a}), 64'b100);
    c = a_frames;
    while (a_frames < c + 3 && busy_a) begin @(posedge clk); #1; end
    init_req_a = 1;
    push_init_a();
    @(posedge clk); #1;
    init_req_a = 0;
    send_cmd_a(4'd5, cmd_data_a, 0);
    check("cmd_after_init_done", 64'(init_done_a), 64'd1);

    // Single-device, fastest timing instance.
    @(posedge clk); #1;
    init_req_b = 1;
    push_init_b();
    @(posedge clk); #1;
    init_req_b = 0;
    for (int i = 0; i < 4; i++) send_cmd_b(4'($urandom_range(0, 15)), 8'($urandom));
    wait_drain("final");
    check("b_init_done", 64'(init_done_b), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
